// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants for the UART TX arbiter: header tag, id width, FSM encodings.
package uart_tx_arbiter_pkg;
    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam int         ID_W    = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    function automatic logic [7:0] hdr_byte(input logic [ID_W-1:0] id);
        return {HDR_TAG, 1'b0, id};
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester byte streams plus the UART_TX write port, bundled for the arbiter.
interface uart_tx_arbiter_if #(parameter int N_REQ = 4);
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0][7:0]  req_data;
    logic [N_REQ-1:0]       req_last;
    logic [N_REQ-1:0]       req_ready;
    logic [7:0]             tx_data;
    logic                   tx_en;
    logic                   tx_full;

    modport master (output req_valid, req_data, req_last, tx_full,
                    input  req_ready, tx_data, tx_en);
    modport slave  (input  req_valid, req_data, req_last, tx_full,
                    output req_ready, tx_data, tx_en);
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request after the last-granted pointer.
module rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_vld
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [IW-1:0] idx;

    always_comb begin
        gnt_id  = '0;
        gnt_vld = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % N_REQ);
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = ID_W'(idx);
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin sharing of one UART_TX byte port, with optional
// source-id header and a forced idle gap after each packet.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int HDR_EN  = 1,
    parameter int GAP_CYC = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             RST,
    uart_tx_arbiter_if.slave bus,
    output logic             busy,
    output logic [ID_W-1:0]  grant_id,
    output logic [CNT_W-1:0] pkt_bytes,
    output logic             pkt_done
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [GW-1:0]    gap_cnt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [IW-1:0]    g;
    logic [ID_W-1:0]  arb_id;
    logic             arb_vld;
    logic             xfer;

    assign g = grant_id[IW-1:0];

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .gnt_id  (arb_id),
        .gnt_vld (arb_vld)
    );

    // tx_en is only ever raised with tx_full low, so every strobe is a guaranteed FIFO write.
    always_comb begin
        bus.tx_en     = 1'b0;
        bus.tx_data   = '0;
        bus.req_ready = '0;
        case (state)
            S_HDR: begin
                bus.tx_en   = ~bus.tx_full;
                bus.tx_data = hdr_byte(grant_id);
            end
            S_PAY: begin
                bus.tx_en        = bus.req_valid[g] & ~bus.tx_full;
                bus.tx_data      = bus.req_data[g];
                bus.req_ready[g] = ~bus.tx_full;
            end
            default: ;
        endcase
    end

    assign xfer    = (state == S_PAY) && bus.tx_en;
    assign busy    = (state != S_IDLE);
    assign cnt_inc = (&byte_cnt) ? byte_cnt : byte_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (RST) begin
            state     <= S_IDLE;
            rr_ptr    <= ID_W'(N_REQ - 1);
            grant_id  <= '0;
            pkt_bytes <= '0;
            pkt_done  <= 1'b0;
            gap_cnt   <= '0;
            byte_cnt  <= '0;
        end else begin
            pkt_done <= 1'b0;
            case (state)
                S_IDLE: if (arb_vld && !bus.tx_full) begin
                    grant_id <= arb_id;
                    rr_ptr   <= arb_id;
                    state    <= (HDR_EN != 0) ? S_HDR : S_PAY;
                end
                S_HDR: if (bus.tx_en) state <= S_PAY;
                S_PAY: if (xfer) begin
                    if (bus.req_last[g]) begin
                        pkt_bytes <= cnt_inc;
                        byte_cnt  <= '0;
                        pkt_done  <= 1'b1;
                        gap_cnt   <= '0;
                        state     <= (GAP_CYC > 0) ? S_GAP : S_IDLE;
                    end else begin
                        byte_cnt <= cnt_inc;
                    end
                end
                default: begin
                    if (gap_cnt == GW'(GAP_CYC - 1)) begin
                        gap_cnt <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed scenario bench for uart_tx_arbiter (default build plus a no-header/no-gap build).
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic RST = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(4)) ifc ();
    uart_tx_arbiter_if #(.N_REQ(4)) ifc2 ();

    logic       busy, busy2, pd, pd2;
    logic [2:0] gid, gid2;
    logic [7:0] pb, pb2;

    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(1), .GAP_CYC(16), .CNT_W(8)) dut (
        .clk(clk), .RST(RST), .bus(ifc.slave),
        .busy(busy), .grant_id(gid), .pkt_bytes(pb), .pkt_done(pd));

    uart_tx_arbiter #(.N_REQ(4), .HDR_EN(0), .GAP_CYC(0), .CNT_W(8)) dut2 (
        .clk(clk), .RST(RST), .bus(ifc2.slave),
        .busy(busy2), .grant_id(gid2), .pkt_bytes(pb2), .pkt_done(pd2));

    int total = 0;
    int bad = 0;

    logic [7:0] mem [4][1024];
    bit         lst [4][1024];
    int         hd[4], tl[4];
    bit         en[4];
    bit         tf, rst_v;
    logic [7:0] txlog [1024];
    int         nlog, done_cnt, inv_bad;
    logic [7:0] last_pb;

    logic       s_en, s_busy, s_pd;
    logic [7:0] s_data, s_pb;
    logic [3:0] s_rdy;
    logic [2:0] s_gid;

    task automatic push(input int r, input logic [7:0] d, input bit l);
        mem[r][tl[r]] = d;
        lst[r][tl[r]] = l;
        tl[r]++;
    endtask

    // One clock: drive at negedge, sample 3ns later (2ns before posedge).
    task automatic cyc();
        logic [3:0] v;
        @(negedge clk);
        RST = rst_v;
        ifc.tx_full = tf;
        for (int i = 0; i < 4; i++) begin
            v[i] = en[i] && (hd[i] != tl[i]);
            ifc.req_valid[i] = v[i];
            ifc.req_data[i]  = v[i] ? mem[i][hd[i]] : 8'h00;
            ifc.req_last[i]  = v[i] && lst[i][hd[i]];
        end
        #3;
        s_en = ifc.tx_en; s_data = ifc.tx_data; s_rdy = ifc.req_ready;
        s_busy = busy; s_gid = gid; s_pd = pd; s_pb = pb;
        if (s_en) begin
            if (nlog < 1024) txlog[nlog] = s_data;
            nlog++;
        end
        if (s_en && tf) inv_bad++;
        if (s_pd) begin done_cnt++; last_pb = s_pb; end
        for (int i = 0; i < 4; i++) if (v[i] && s_rdy[i]) hd[i]++;
    endtask

    task automatic do_reset();
        rst_v = 1'b1; tf = 1'b0;
        for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; en[i] = 1'b1; end
        cyc(); cyc();
        rst_v = 1'b0;
        nlog = 0; done_cnt = 0;
    endtask

    task automatic test_reset();
        rst_v = 1'b1;
        for (int i = 0; i < 4; i++) begin hd[i] = 0; tl[i] = 0; en[i] = 1'b1; end
        cyc(); cyc();
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", s_busy); end
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL reset_tx_en got %b want 0", s_en); end
        total++; if (s_rdy !== 4'h0) begin bad++; $display("FAIL reset_ready got %h want 0", s_rdy); end
        total++; if (s_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got %h want 00", s_data); end
        total++; if (s_gid !== 3'd0) begin bad++; $display("FAIL reset_grant got %0d want 0", s_gid); end
        total++; if (s_pb !== 8'h00) begin bad++; $display("FAIL reset_pkt_bytes got %h want 00", s_pb); end
        total++; if (s_pd !== 1'b0) begin bad++; $display("FAIL reset_pkt_done got %b want 0", s_pd); end
        total++; if (busy2 !== 1'b0) begin bad++; $display("FAIL reset_busy2 got %b want 0", busy2); end
        rst_v = 1'b0;
        nlog = 0; done_cnt = 0;
    endtask

    task automatic test_single();
        logic [7:0] e [4] = '{8'hA0, 8'h11, 8'h22, 8'h33};
        int gb = 1;
        do_reset();
        push(0, 8'h11, 0); push(0, 8'h22, 0); push(0, 8'h33, 1);
        for (int k = 0; k < 60 && done_cnt == 0; k++) cyc();
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done got %0d want 1", done_cnt); end
        total++; if (last_pb !== 8'd3) begin bad++; $display("FAIL single_pkt_bytes got %0d want 3", last_pb); end
        total++; if (s_busy !== 1'b1) begin bad++; $display("FAIL single_gap_busy got %b want 1", s_busy); end
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (!s_busy) break;
            gb++;
        end
        total++; if (gb !== 16) begin bad++; $display("FAIL single_gap_len got %0d want 16", gb); end
        total++; if (done_cnt !== 1) begin bad++; $display("FAIL single_done_once got %0d want 1", done_cnt); end
        total++; if (nlog !== 4) begin bad++; $display("FAIL single_nbytes got %0d want 4", nlog); end
        for (int k = 0; k < 4; k++) begin
            total++; if (txlog[k] !== e[k]) begin bad++; $display("FAIL single_byte%0d got %h want %h", k, txlog[k], e[k]); end
        end
    endtask

    task automatic test_rr();
        logic [7:0] e [10] = '{8'hA0, 8'h50, 8'hA1, 8'h51, 8'hA2, 8'h52, 8'hA3, 8'h53, 8'hA0, 8'h60};
        do_reset();
        push(0, 8'h50, 1); push(1, 8'h51, 1); push(2, 8'h52, 1); push(3, 8'h53, 1); push(0, 8'h60, 1);
        for (int k = 0; k < 300 && done_cnt < 5; k++) cyc();
        total++; if (done_cnt !== 5) begin bad++; $display("FAIL rr_done got %0d want 5", done_cnt); end
        total++; if (nlog !== 10) begin bad++; $display("FAIL rr_nbytes got %0d want 10", nlog); end
        for (int k = 0; k < 10; k++) begin
            total++; if (txlog[k] !== e[k]) begin bad++; $display("FAIL rr_byte%0d got %h want %h", k, txlog[k], e[k]); end
        end
    endtask

    task automatic test_full();
        logic [7:0] e [5] = '{8'hA1, 8'h31, 8'h32, 8'h33, 8'h34};
        int viol = 0;
        do_reset();
        push(1, 8'h31, 0); push(1, 8'h32, 0); push(1, 8'h33, 0); push(1, 8'h34, 1);
        for (int k = 0; k < 20 && nlog < 2; k++) cyc();
        tf = 1'b1;
        repeat (10) begin
            cyc();
            if (s_en || s_rdy != 4'h0 || !s_busy || s_gid != 3'd1) viol++;
        end
        tf = 1'b0;
        for (int k = 0; k < 40 && done_cnt == 0; k++) cyc();
        total++; if (viol !== 0) begin bad++; $display("FAIL full_hold got %0d bad cycles want 0", viol); end
        total++; if (nlog !== 5) begin bad++; $display("FAIL full_nbytes got %0d want 5", nlog); end
        total++; if (last_pb !== 8'd4) begin bad++; $display("FAIL full_pkt_bytes got %0d want 4", last_pb); end
        for (int k = 0; k < 5; k++) begin
            total++; if (txlog[k] !== e[k]) begin bad++; $display("FAIL full_byte%0d got %h want %h", k, txlog[k], e[k]); end
        end
    endtask

    task automatic test_drop();
        logic [7:0] e [7] = '{8'hA1, 8'h41, 8'h42, 8'h43, 8'h44, 8'hA2, 8'h71};
        int viol = 0;
        do_reset();
        push(1, 8'h41, 0); push(1, 8'h42, 0); push(1, 8'h43, 0); push(1, 8'h44, 1);
        push(2, 8'h71, 1);
        for (int k = 0; k < 20 && nlog < 3; k++) cyc();
        en[1] = 1'b0;
        repeat (5) begin
            cyc();
            if (s_en || !s_busy || s_gid != 3'd1) viol++;
        end
        en[1] = 1'b1;
        for (int k = 0; k < 100 && done_cnt < 2; k++) cyc();
        total++; if (viol !== 0) begin bad++; $display("FAIL drop_hold got %0d bad cycles want 0", viol); end
        total++; if (nlog !== 7) begin bad++; $display("FAIL drop_nbytes got %0d want 7", nlog); end
        for (int k = 0; k < 7; k++) begin
            total++; if (txlog[k] !== e[k]) begin bad++; $display("FAIL drop_byte%0d got %h want %h", k, txlog[k], e[k]); end
        end
    endtask

    task automatic test_reset_mid();
        nlog = 0; done_cnt = 0;
        push(3, 8'hC1, 0); push(3, 8'hC2, 0); push(3, 8'hC3, 0); push(3, 8'hC4, 1);
        push(0, 8'h01, 1);
        for (int k = 0; k < 60 && nlog < 3; k++) cyc();
        total++; if (txlog[0] !== 8'hA3) begin bad++; $display("FAIL rmid_first_hdr got %h want a3", txlog[0]); end
        hd[3] = tl[3];
        rst_v = 1'b1; cyc(); rst_v = 1'b0;
        cyc();
        total++; if (s_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got %b want 0", s_busy); end
        total++; if (s_en !== 1'b0) begin bad++; $display("FAIL rmid_tx_en got %b want 0", s_en); end
        cyc();
        total++; if (s_gid !== 3'd0) begin bad++; $display("FAIL rmid_grant got %0d want 0", s_gid); end
        total++; if (s_data !== 8'hA0 || s_en !== 1'b1) begin bad++; $display("FAIL rmid_hdr got %h/%b want a0/1", s_data, s_en); end
        done_cnt = 0;
        for (int k = 0; k < 20 && done_cnt == 0; k++) cyc();
        total++; if (last_pb !== 8'd1) begin bad++; $display("FAIL rmid_pkt_bytes got %0d want 1", last_pb); end
    endtask

    task automatic test_back_to_back();
        int idx = 0, ntx = 0, dn = 0, idle = 0, guard = 0;
        logic [7:0] first = 8'hFF, p1 = 8'h00, p2 = 8'h00;
        bit got_first = 1'b0;
        do_reset();
        while ((idx < 302 || dn < 2) && guard < 500) begin
            @(negedge clk);
            RST = 1'b0;
            ifc2.req_valid   = {3'b000, idx < 302};
            ifc2.req_data[0] = idx[7:0];
            ifc2.req_last    = {3'b000, (idx == 299) || (idx == 301)};
            #3;
            if (ifc2.tx_en) begin
                if (!got_first) first = ifc2.tx_data;
                got_first = 1'b1;
                ntx++;
            end
            if (pd2) begin
                dn++;
                if (dn == 1) p1 = pb2; else p2 = pb2;
            end
            if (dn == 1 && !busy2) idle++;
            if (ifc2.req_valid[0] && ifc2.req_ready[0]) idx++;
            guard++;
        end
        ifc2.req_valid = '0;
        total++; if (guard >= 500) begin bad++; $display("FAIL b2b_timeout got %0d cycles want <500", guard); end
        total++; if (first !== 8'h00) begin bad++; $display("FAIL b2b_no_header got %h want 00", first); end
        total++; if (ntx !== 302) begin bad++; $display("FAIL b2b_nbytes got %0d want 302", ntx); end
        total++; if (p1 !== 8'hFF) begin bad++; $display("FAIL b2b_saturate got %0d want 255", p1); end
        total++; if (p2 !== 8'd2) begin bad++; $display("FAIL b2b_pkt2_bytes got %0d want 2", p2); end
        total++; if (idle !== 1) begin bad++; $display("FAIL b2b_idle_gap got %0d want 1", idle); end
        total++; if (dn !== 2) begin bad++; $display("FAIL b2b_done got %0d want 2", dn); end
    endtask

    initial begin
        ifc2.req_valid = '0; ifc2.req_data = '0; ifc2.req_last = '0; ifc2.tx_full = 1'b0;
        inv_bad = 0;
        test_reset();
        test_single();
        test_rr();
        test_full();
        test_drop();
        test_reset_mid();
        test_back_to_back();
        total++; if (inv_bad !== 0) begin bad++; $display("FAIL tx_en_while_full got %0d want 0", inv_bad); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
